tt_um_xform_pipe: RTL

// - Tiny Tapeout user top. Successor to the single-function inverter top.
// - Registered, pipelined 8-bit transform engine with a run-time selectable mode:

---
 rtl/tt_xform_pkg.sv | 33 +++
 rtl/tt_xform_lfsr.sv | 45 ++++
 rtl/tt_um_xform_pipe.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/tt_xform_pkg.sv
// Shared definitions for the tt_um_xform_pipe transform engine.
//   - mode_e       : transform selector encodings
//   - uio bit index: positions of the control fields on uio_in
//   - UIO_OE_MASK  : output-enable pattern for the bidirectional pins
//   - bit_reverse  : out[i] = d[7-i]
package tt_xform_pkg;

    typedef enum logic [1:0] {
        MODE_INV  = 2'b00,
        MODE_XOR  = 2'b01,
        MODE_LFSR = 2'b10,
        MODE_REV  = 2'b11
    } mode_e;

    // Control field positions on uio_in
    localparam int unsigned CFG_WE   = 7;
    localparam int unsigned VALID_IN = 6;
    localparam int unsigned CFG_SEL  = 5;
    localparam int unsigned HOLD     = 4;
    localparam int unsigned MODE_LSB = 2;

    // uio[1:0] are outputs (valid_out, parity); the rest are inputs
    localparam logic [7:0] UIO_OE_MASK = 8'h03;

    function automatic logic [7:0] bit_reverse(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = d[7 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/tt_xform_lfsr.sv
// 8-bit Galois LFSR used as the scramble key source.
//   clk      in   clock, rising edge
//   rst_n    in   synchronous active-low reset (state <= SEED)
//   load     in   load a new seed; takes priority over step
//   load_val in   seed value; zero is replaced by 8'h01 to avoid lock-up
//   step     in   advance one position
//   state    out  current LFSR value
module tt_xform_lfsr
    import tt_xform_pkg::*;
#(
    parameter logic [7:0] POLY = 8'hB8,
    parameter logic [7:0] SEED = 8'h01
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       step,
    output logic [7:0] state
);

    logic [7:0] state_q;
    logic [7:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            // All-zero is the LFSR's dead state; substitute the smallest legal seed
            state_d = (load_val == 8'h00) ? 8'h01 : load_val;
        end else if (step) begin
            state_d = {1'b0, state_q[7:1]} ^ (state_q[0] ? POLY : 8'h00);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/tt_um_xform_pipe.sv
// Tiny Tapeout user top: pipelined 8-bit transform engine.
// The transform (invert, XOR key, LFSR scramble, bit-reverse) is applied at
// stage 0; later stages only carry data and valid towards uo_out.
//   clk      in   clock, rising edge
//   rst_n    in   synchronous active-low reset
//   ena      in   design enabled; low freezes everything like hold
//   ui_in    in   data in, or config payload when cfg_we=1
//   uio_in   in   [7]cfg_we [6]valid_in [5]cfg_sel [4]hold [3:2]mode [1:0]unused
//   uo_out   out  data from the last pipe stage
//   uio_out  out  [0]valid_out [1]even parity of uo_out [7:2]=0
//   uio_oe   out  constant 8'h03
module tt_um_xform_pipe
    import tt_xform_pkg::*;
#(
    parameter int unsigned PIPE_STAGES  = 2,
    parameter logic [7:0]  LFSR_POLY    = 8'hB8,
    parameter logic [1:0]  RESET_MODE   = 2'b00,
    parameter logic [7:0]  SEED_DEFAULT = 8'h01
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic cfg_we;
    logic valid_in;
    logic cfg_sel;
    logic hold;
    logic advance;
    logic accept;
    logic cfg_wr;

    assign cfg_we   = uio_in[CFG_WE];
    assign valid_in = uio_in[VALID_IN];
    assign cfg_sel  = uio_in[CFG_SEL];
    assign hold     = uio_in[HOLD];

    // Single enable for every piece of state; ena=0 is treated as hold
    assign advance = ena & ~hold;
    // Config cycles never carry data, even with valid_in set
    assign accept  = valid_in & ~cfg_we & advance;
    assign cfg_wr  = cfg_we & advance;

    logic unused_uio;
    assign unused_uio = ^uio_in[1:0];

    // ------------------------------------------------------------------
    // Config registers
    // ------------------------------------------------------------------
    mode_e      mode_q;
    mode_e      mode_d;
    logic [7:0] key_q;
    logic [7:0] key_d;

    always_comb begin
        mode_d = mode_q;
        key_d  = key_q;
        if (cfg_wr) begin
            if (cfg_sel) begin
                key_d = ui_in;
            end else begin
                mode_d = mode_e'(uio_in[MODE_LSB +: 2]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q <= mode_e'(RESET_MODE);
            key_q  <= 8'h00;
        end else begin
            mode_q <= mode_d;
            key_q  <= key_d;
        end
    end

    // ------------------------------------------------------------------
    // Scramble source: reseeded together with key, stepped only when its
    // value is consumed so the sequence is independent of idle cycles.
    // ------------------------------------------------------------------
    logic [7:0] lfsr_state;
    logic       lfsr_load;
    logic       lfsr_step;

    assign lfsr_load = cfg_wr & cfg_sel;
    assign lfsr_step = accept & (mode_q == MODE_LFSR);

    tt_xform_lfsr #(
        .POLY (LFSR_POLY),
        .SEED (SEED_DEFAULT)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lfsr_load),
        .load_val (ui_in),
        .step     (lfsr_step),
        .state    (lfsr_state)
    );

    // ------------------------------------------------------------------
    // Stage-0 transform
    // ------------------------------------------------------------------
    logic [7:0] xform;
    logic [7:0] stage0_data;

    always_comb begin
        xform = ~ui_in;
        unique case (mode_q)
            MODE_INV:  xform = ~ui_in;
            MODE_XOR:  xform = ui_in ^ key_q;
            MODE_LFSR: xform = ui_in ^ lfsr_state;
            MODE_REV:  xform = bit_reverse(ui_in);
        endcase
    end

    // Bubbles carry zero data so uo_out is deterministic when valid_out=0
    assign stage0_data = accept ? xform : 8'h00;

    // ------------------------------------------------------------------
    // Pipeline stages
    // ------------------------------------------------------------------
    logic [7:0] stage_data  [PIPE_STAGES];
    logic       stage_valid [PIPE_STAGES];

    for (genvar i = 0; i < PIPE_STAGES; i++) begin : gen_stage
        logic [7:0] data_in;
        logic       valid_s;
        logic [7:0] data_q;
        logic       valid_q;

        if (i == 0) begin : gen_head
            assign data_in = stage0_data;
            assign valid_s = accept;
        end else begin : gen_body
            assign data_in = stage_data[i - 1];
            assign valid_s = stage_valid[i - 1];
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                data_q  <= 8'h00;
                valid_q <= 1'b0;
            end else if (advance) begin
                data_q  <= data_in;
                valid_q <= valid_s;
            end
        end

        assign stage_data[i]  = data_q;
        assign stage_valid[i] = valid_q;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign uo_out  = stage_data[PIPE_STAGES - 1];
    assign uio_out = {6'b00_0000, ^uo_out, stage_valid[PIPE_STAGES - 1]};
    assign uio_oe  = UIO_OE_MASK;

endmodule
